store_merge_unit: RTL and testbench

Sequential, parametrised store-size engine between the datapath's store path and the data memory port. For sub-word stores it performs a full read-modify-write: it reads the addressed memory word, replaces the byte or halfword lane selected by the address offset, and writes the merged word back. Word stores are written directly, with no read. Misaligned or invalid requests are rejected with no memory access. All handshakes tolerate memory wait states.

---
 rtl/store_merge_unit.sv | 127 ++++++++++++
 tb/tb_store_merge_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// Store-size engine: word stores go straight to memory, byte/half stores do a
// read-modify-write of the containing word, misaligned/invalid requests are rejected.

module store_merge_lane #(
  parameter int OFF_W = 2,
  parameter int LANE  = 0
) (
  input  logic [OFF_W-1:0] off,
  input  logic             is_half,
  input  logic [15:0]      wdata,
  input  logic [7:0]       rdata,
  output logic [7:0]       merged
);
  // Halves are 2-byte aligned, so the upper byte lane is always off|1.
  logic [OFF_W-1:0] off_hi;
  assign off_hi = {off[OFF_W-1:1], 1'b1};

  always_comb begin
    merged = rdata;
    if (off == OFF_W'(LANE))                   merged = wdata[7:0];
    else if (is_half && off_hi == OFF_W'(LANE)) merged = wdata[15:8];
  end
endmodule

module store_merge_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int OFF_W     = $clog2(NUM_LANES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]                   state, state_nxt;
  logic [1:0]                   size_q;
  logic [OFF_W-1:0]             off_q;
  logic [15:0]                  wdata_q;
  logic [ADDR_W-1:0]            addr_q;
  logic [DATA_W-1:0]            merge_q;
  logic [NUM_LANES-1:0][7:0]    merged;
  logic [OFF_W-1:0]             off_in;
  logic                         req_ok;

  assign off_in = addr[OFF_W-1:0];

  always_comb begin
    case (size)
      2'b01:   req_ok = (off_in == '0);
      2'b10:   req_ok = ~off_in[0];
      2'b11:   req_ok = 1'b1;
      default: req_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = !req_ok ? S_ERR : (size == 2'b01) ? S_WRITE : S_READ;
      S_READ:  if (mem_ready) state_nxt = S_WRITE;
      S_WRITE: if (mem_ready) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    store_merge_lane #(.OFF_W(OFF_W), .LANE(i)) u_lane (
      .off     (off_q),
      .is_half (size_q == 2'b10),
      .wdata   (wdata_q),
      .rdata   (mem_rdata[8*i +: 8]),
      .merged  (merged[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      size_q  <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      merge_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        size_q  <= size;
        off_q   <= off_in;
        wdata_q <= wdata[15:0];
        addr_q  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        merge_q <= wdata;
      end else if (state == S_READ && mem_ready) begin
        merge_q <= merged;
      end
    end
  end

  // Every output is a register or a pure decode of state.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE) || (state == S_ERR);
  assign err       = (state == S_ERR);
  assign mem_rd    = (state == S_READ);
  assign mem_wr    = (state == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = merge_q;
endmodule

// File: tb/tb_store_merge_unit.sv
// Randomised bench for store_merge_unit: drives a 32-bit and a 64-bit instance
// with a wait-state memory and compares against an arithmetic store model.

module tb_store_merge_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel64 = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [63:0] rdata = '0;
  logic        ready = 1'b0;

  logic        busy32, done32, err32, rd32, wr32;
  logic [31:0] maddr32, mwd32;
  logic        busy64, done64, err64, rd64, wr64;
  logic [31:0] maddr64;
  logic [63:0] mwd64;

  store_merge_unit #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .start(start & ~sel64), .size(size), .addr(addr),
    .wdata(wdata[31:0]), .busy(busy32), .done(done32), .err(err32), .mem_addr(maddr32),
    .mem_rd(rd32), .mem_wr(wr32), .mem_wdata(mwd32), .mem_rdata(rdata[31:0]),
    .mem_ready(ready & ~sel64)
  );

  store_merge_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .start(start & sel64), .size(size), .addr(addr),
    .wdata(wdata), .busy(busy64), .done(done64), .err(err64), .mem_addr(maddr64),
    .mem_rd(rd64), .mem_wr(wr64), .mem_wdata(mwd64), .mem_rdata(rdata),
    .mem_ready(ready & sel64)
  );

  logic        o_busy, o_done, o_err, o_rd, o_wr;
  logic [31:0] o_maddr;
  logic [63:0] o_wdata;
  assign o_busy  = sel64 ? busy64  : busy32;
  assign o_done  = sel64 ? done64  : done32;
  assign o_err   = sel64 ? err64   : err32;
  assign o_rd    = sel64 ? rd64    : rd32;
  assign o_wr    = sel64 ? wr64    : wr32;
  assign o_maddr = sel64 ? maddr64 : maddr32;
  assign o_wdata = sel64 ? mwd64   : {32'b0, mwd32};

  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] last_wd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction; memory inserts rdw/wrw wait cycles on read/write.
  task automatic run_op(input bit w64, input logic [1:0] sz, input logic [31:0] a,
                        input logic [63:0] wd, input logic [63:0] rd,
                        input int rdw, input int wrw, input bit dbl);
    int          nbytes, off, k, done_k, nrd, nwr, exp_k;
    bit          valid, both, addr_bad, err_seen, busy_at_done;
    logic [63:0] dmask, m, exp_wd, wcap;
    logic [31:0] exp_addr;

    nbytes   = w64 ? 8 : 4;
    dmask    = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    off      = int'(a % nbytes);
    exp_addr = a - (a % nbytes);
    case (sz)
      2'b01:   valid = (off == 0);
      2'b10:   valid = (off % 2 == 0);
      2'b11:   valid = 1'b1;
      default: valid = 1'b0;
    endcase
    if (sz == 2'b11)      m = 64'hFF << (8*off);
    else if (sz == 2'b10) m = 64'hFFFF << (8*off);
    else                  m = '1;
    exp_wd = (((rd & ~m) | ((wd << (8*off)) & m)) & dmask);
    if (!valid)            exp_k = 1;
    else if (sz == 2'b01)  exp_k = 2 + wrw;
    else                   exp_k = 3 + rdw + wrw;

    @(negedge clk);
    sel64 = w64; start = 1'b1; size = sz; addr = a; wdata = wd;
    ready = 1'($urandom); rdata = {$urandom, $urandom};
    @(posedge clk);
    k = 0; done_k = -1; nrd = 0; nwr = 0; both = 0; addr_bad = 0;
    err_seen = 0; busy_at_done = 0; wcap = '0;
    while (k < 60) begin
      @(negedge clk);
      k++;
      start = dbl && (k == 1);
      if (dbl && k == 1) begin
        size = 2'b01; addr = a ^ 32'h40; wdata = ~wd;
      end
      if (o_rd && o_wr) both = 1;
      if (o_rd) begin
        if (o_maddr !== exp_addr) addr_bad = 1;
        nrd++;
        ready = (nrd == rdw + 1);
        rdata = ready ? rd : {$urandom, $urandom};
      end else if (o_wr) begin
        if (o_maddr !== exp_addr) addr_bad = 1;
        nwr++;
        ready = (nwr == wrw + 1);
        if (ready) wcap = o_wdata;
        rdata = {$urandom, $urandom};
      end else begin
        ready = 1'($urandom);
        rdata = {$urandom, $urandom};
      end
      if (o_done) begin
        done_k = k; err_seen = o_err; busy_at_done = o_busy;
        break;
      end
    end
    start = 1'b0;
    chk("done_latency", 64'(done_k), 64'(exp_k));
    chk("err", 64'(err_seen), 64'(!valid));
    chk("rd_cycles", 64'(nrd), (valid && sz != 2'b01) ? 64'(rdw + 1) : 64'd0);
    chk("wr_cycles", 64'(nwr), valid ? 64'(wrw + 1) : 64'd0);
    chk("rd_wr_overlap", 64'(both), 64'd0);
    chk("mem_addr", 64'(addr_bad), 64'd0);
    chk("busy_at_done", 64'(busy_at_done), 64'd1);
    if (valid) chk("mem_wdata", wcap, exp_wd);
    last_wd = wcap;
    @(negedge clk);
    chk("idle_busy", 64'(o_busy), 64'd0);
    chk("idle_done", 64'(o_done), 64'd0);
    if (dbl) begin
      @(negedge clk);
      chk("no_second_txn", 64'({o_busy, o_rd, o_wr}), 64'd0);
    end
  endtask

  initial begin
    // Reset state on both widths
    #2;
    chk("rst_busy", 64'({busy32, busy64}), 64'd0);
    chk("rst_done_err", 64'({done32, done64, err32, err64}), 64'd0);
    chk("rst_rd_wr", 64'({rd32, wr32, rd64, wr64}), 64'd0);
    chk("rst_addr", 64'({maddr32, maddr64}), 64'd0);
    chk("rst_wdata32", 64'(mwd32), 64'd0);
    chk("rst_wdata64", mwd64, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op(0, 2'b11, 32'h1002, 64'h0000_00AB, 64'h1122_3344, 0, 0, 0);
    chk("tp_byte", last_wd, 64'h11AB_3344);
    run_op(0, 2'b10, 32'h2002, 64'h0000_BEEF, 64'hCAFE_1234, 2, 0, 0);
    chk("tp_half_wait", last_wd, 64'hBEEF_1234);
    run_op(0, 2'b01, 32'h3000, 64'hDEAD_BEEF, 64'h0, 0, 0, 0);
    chk("tp_word", last_wd, 64'hDEAD_BEEF);
    run_op(0, 2'b10, 32'h4001, 64'h1234, 64'h0, 0, 0, 0);
    run_op(0, 2'b01, 32'h4002, 64'h1234, 64'h0, 0, 0, 0);
    run_op(0, 2'b00, 32'h4000, 64'h1234, 64'h0, 0, 0, 0);

    // Reset while a byte store is stalled in READ
    @(negedge clk);
    sel64 = 0; start = 1; size = 2'b11; addr = 32'h1001; wdata = 64'h55; ready = 0;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    chk("midop_rd", 64'({o_rd, o_busy}), 64'b11);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_rd_busy", 64'({o_rd, o_wr, o_busy}), 64'd0);
    chk("abort_done", 64'(o_done), 64'd0);
    @(negedge clk);
    chk("abort_no_done", 64'(o_done), 64'd0);
    reset_n = 1'b1;
    run_op(0, 2'b11, 32'h1001, 64'h55, 64'hA0B0_C0D0, 1, 1, 0);
    chk("post_reset_byte", last_wd, 64'hA0B0_55D0);

    run_op(1, 2'b10, 32'h5006, 64'h7777, 64'h0123_4567_89AB_CDEF, 0, 0, 1);
    chk("tp_half64", last_wd, 64'h7777_4567_89AB_CDEF);

    for (int i = 0; i < 60; i++) begin
      run_op(bit'(i % 2), 2'($urandom_range(0, 3)), $urandom, {$urandom, $urandom},
             {$urandom, $urandom}, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
             bit'($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
